// File: rtl/lns_delta_pipe.sv
`timescale 1ns/1ps
// Three-stage LNS delta approximation (delta-plus / delta-minus) with a global
// stall, tag sideband and a saturating count of results forced to zero.
module lns_delta_pipe #(
    parameter int WBITS    = 16,
    parameter int FRACBITS = 8,
    parameter int TAGW     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WBITS-1:0] in_diff,
    input  logic             in_sign,
    input  logic             in_interp,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WBITS-1:0] out_res,
    output logic [TAGW-1:0]  out_tag,
    output logic [15:0]      sat_count,
    input  logic             sat_clr
);
    localparam int STAGES = 3;
    localparam int KW     = WBITS - FRACBITS;

    localparam logic [WBITS-1:0] ONE         = WBITS'(1) << FRACBITS;
    localparam logic [WBITS-1:0] ONE_PT_FIVE = WBITS'(3) << (FRACBITS - 1);
    localparam logic [WBITS-1:0] MSB_MASK    = WBITS'(1) << (WBITS - 1);
    localparam logic [WBITS-1:0] MAX_POS     = ~MSB_MASK;

    typedef struct packed {
        logic [KW-1:0]       k;
        logic [FRACBITS-1:0] f;
        logic                sign;
        logic                interp;
        logic [TAGW-1:0]     tag;
    } s1_t;

    typedef struct packed {
        logic [WBITS-1:0] mag_res;
        logic             sat;
        logic             sign;
        logic [TAGW-1:0]  tag;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            en;
    logic            out_sat;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic [WBITS-1:0]   mag;
    logic [WBITS-1:0]   base;
    logic [2*WBITS-1:0] prod;
    logic [2*WBITS-1:0] corr;
    logic [WBITS-1:0]   res_d;

    assign out_valid = vld_pipe[STAGES];
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;

    // Stage 1: magnitude split into integer shift and interpolation fraction
    always_comb begin
        mag = in_diff;
        if (in_diff == MSB_MASK)
            mag = MAX_POS;
        else if (in_diff[WBITS-1])
            mag = -in_diff;
        s1_d.k      = mag[WBITS-1:FRACBITS];
        s1_d.f      = mag[FRACBITS-1:0];
        s1_d.sign   = in_sign;
        s1_d.interp = in_interp;
        s1_d.tag    = in_tag;
    end

    // Stage 2: shifted base, optional truncating linear correction
    always_comb begin
        s2_d.sat  = WBITS'(s1_q.k) > WBITS'(FRACBITS);
        base      = (s1_q.sign ? ONE : ONE_PT_FIVE) >> s1_q.k;
        if (s2_d.sat)
            base = '0;
        prod = {{WBITS{1'b0}}, base} * {{(2*WBITS-FRACBITS){1'b0}}, s1_q.f};
        corr = prod >> (FRACBITS + 1);
        s2_d.mag_res = s1_q.interp ? (base - corr[WBITS-1:0]) : base;
        s2_d.sign    = s1_q.sign;
        s2_d.tag     = s1_q.tag;
    end

    // Stage 3: delta-minus results carry the MSB flag unless they are zero
    assign res_d = (!s2_q.sign && s2_q.mag_res != '0) ? (s2_q.mag_res | MSB_MASK)
                                                      : s2_q.mag_res;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            out_res   <= '0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
            sat_count <= '0;
        end else begin
            if (en) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
                if (vld_pipe[STAGES-1]) begin
                    out_res <= res_d;
                    out_tag <= s2_q.tag;
                    out_sat <= s2_q.sat;
                end
            end
            if (sat_clr)
                sat_count <= '0;
            else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: doc/lns_delta_pipe.md
LNS_DELTA_PIPE -- requirements
Module: lns_delta_pipe

Interface
REQ-001 Parameter WBITS, default 16, total word width of diff and result (signed fixed point).
REQ-002 Parameter FRACBITS, default 8, fraction bits; legal range 1..WBITS-2.
REQ-003 Parameter TAGW, default 4, width of the sideband tag carried with each transaction.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1  asynchronous reset, active-low.
REQ-006 Port in_valid  input  1  input transaction present.
REQ-007 Port in_ready  output  1  block accepts the input this cycle.
REQ-008 Port in_diff  input  WBITS  signed difference of log operands.
REQ-009 Port in_sign  input  1  1 = delta-plus, 0 = delta-minus.
REQ-010 Port in_interp  input  1  1 = linear interpolation on the fraction, 0 = plain bit-shift.
REQ-011 Port in_tag  input  TAGW  opaque tag, returned unchanged with the result.
REQ-012 Port out_valid  output  1  result present.
REQ-013 Port out_ready  input  1  downstream accepts the result.
REQ-014 Port out_res  output  WBITS  delta result.
REQ-015 Port out_tag  output  TAGW  tag of the result.
REQ-016 Port sat_count  output  16  count of results forced to zero.
REQ-017 Port sat_clr  input  1  synchronous clear of sat_count.

Function
REQ-018 ONE = 1<<FRACBITS; ONE_PT_FIVE = 3<<(FRACBITS-1); MSB_MASK = 1<<(WBITS-1).
REQ-019 Stage 1 forms mag = |in_diff|; the most negative input saturates to 2^(WBITS-1)-1.
REQ-020 Integer part k = mag>>FRACBITS (WBITS-FRACBITS bits, unsigned); fraction f = mag[FRACBITS-1:0].
REQ-021 Stage 2 forms base = ONE>>k when sign=1 and base = ONE_PT_FIVE>>k when sign=0; k > FRACBITS forces base = 0 and flags saturation.
REQ-022 Interp off: mag_res = base.
REQ-023 Interp on: mag_res = base - ((base*f)>>(FRACBITS+1)); the product is unsigned at full width (2*WBITS) and the result is truncated, never rounded.
REQ-024 Stage 3 sets out_res = mag_res | MSB_MASK when sign=0 and mag_res != 0; otherwise out_res = mag_res.
REQ-025 A saturated result is all zeros, with no MSB_MASK, in both modes.
REQ-026 Pipeline is 3 stages; latency is 3 cycles from an accepted input to out_valid when there is no stall; throughput is 1 per cycle.
REQ-027 Global stall: en = out_ready | ~out_valid; all stages advance only when en=1; in_ready = en.
REQ-028 A transfer occurs when valid and ready are both high; a bubble propagates as a stage valid=0.
REQ-029 While out_valid=1 and out_ready=0, out_res and out_tag hold stable and all stage contents are frozen.
REQ-030 Each stage carries sign, interp and tag alongside its data; out_tag always equals the tag of the same transaction.
REQ-031 sat_count increments by 1 when a saturated result transfers out (out_valid & out_ready); it holds at 0xFFFF and does not wrap.
REQ-032 sat_clr=1 sets sat_count to 0 next cycle and takes priority over a simultaneous increment.
REQ-033 Results leave in acceptance order; no transaction is dropped or duplicated under any out_ready pattern.

Reset
REQ-034 rst_n=0 immediately clears all stage valids, out_valid=0, out_res=0, out_tag=0 and sat_count=0, independent of clk.
REQ-035 Reset mid-operation discards in-flight transactions; in_ready=1 on the first cycle after deassertion.
REQ-036 Datapath registers other than the outputs need not be reset; only the valids are control-relevant.

Verification (WBITS=16, FRACBITS=8)
REQ-037 Plain mode, diff=0x0200: sign=1 gives 0x0040 and sign=0 gives 0x8060, each 3 cycles after acceptance.
REQ-038 Interp mode, diff=0x0180: sign=1 gives 0x0060 and sign=0 gives 0x8090.
REQ-039 Sign and saturation: diff=0xFE00 gives the same result as 0x0200; diff=0x0900 and diff=0x8000 give 0x0000, and sat_count advances by 2.
REQ-040 Backpressure: stream 8 tagged inputs with out_ready toggling randomly -> all 8 results in order, correct tags, outputs stable while stalled.
REQ-041 Counter edges: preload sat_count to 0xFFFF then add a saturated result -> stays 0xFFFF; assert sat_clr together with a saturated transfer -> 0.
REQ-042 Reset: assert rst_n=0 with 3 transactions in flight -> out_valid=0 at once, no stale result after release, next input completes normally.
